encoder8_serializer: RTL and testbench

Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 decoder. Accepts an 8-bit request vector over a valid/ready handshake and emits the 3-bit index of every set bit, one index per beat, in priority order, over a second valid/ready handshake. Used wherever a group of one-hot or multi-hot select lines must be turned back into binary addresses for the ALU control path.

---
 rtl/encoder8_serializer_pkg.sv | 22 ++
 rtl/encoder8_serializer_prio_enc8.sv | 26 ++
 rtl/encoder8_serializer.sv | 62 ++++++
 tb/tb_encoder8_serializer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/encoder8_serializer_pkg.sv
// Shared definitions for the 8-to-3 serializing encoder: widths, FSM states
// and a population-count helper.
package encoder8_serializer_pkg;

  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } stateT;

  function automatic logic [3:0] popCount(input logic [REQ_W-1:0] vec);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < REQ_W; i++) begin
      cnt = cnt + 4'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/encoder8_serializer_prio_enc8.sv
// Combinational 8-to-3 priority encoder; lsbFirst selects whether the lowest
// or the highest set bit wins. anySet flags a non-empty vector.
module prio_enc8
  import encoder8_serializer_pkg::*;
(
  input  logic [REQ_W-1:0]  vec,
  input  logic              lsbFirst,
  output logic [CODE_W-1:0] idx,
  output logic              anySet
);

  // Later matches override earlier ones, so scan towards the winning end.
  always_comb begin
    idx = '0;
    for (int i = 0; i < REQ_W; i++) begin
      if (lsbFirst) begin
        if (vec[REQ_W-1-i]) idx = CODE_W'(REQ_W-1-i);
      end else begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
  end

  assign anySet = |vec;

endmodule

// File: rtl/encoder8_serializer.sv
// Sequential 8-to-3 encoder: takes a multi-hot request vector and streams the
// index of each set bit, one per beat, over a valid/ready output handshake.
module encoder8_serializer
  import encoder8_serializer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [REQ_W-1:0]  req,
  output logic              outValid,
  input  logic              outReady,
  output logic [CODE_W-1:0] code,
  output logic              last,
  output logic              zero
);

  stateT             state;
  logic [REQ_W-1:0]  pend;
  logic              zReg;
  logic [CODE_W-1:0] prioIdx;
  logic              anySet;
  logic              emitting;
  logic              accept;
  logic              xfer;

  prio_enc8 uPrio (
    .vec      (pend),
    .lsbFirst (LSB_FIRST),
    .idx      (prioIdx),
    .anySet   (anySet)
  );

  assign emitting = (state == EMIT);
  assign outValid = emitting;
  assign code     = emitting ? prioIdx : '0;
  assign last     = emitting && (!anySet || (popCount(pend) == 4'd1));
  assign zero     = emitting && zReg;

  // Ready again on the final beat's transfer so back-to-back vectors need no bubble.
  assign inReady  = !emitting || (outReady && last);
  assign accept   = inValid && inReady;
  assign xfer     = outValid && outReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      zReg  <= 1'b0;
    end else if (accept) begin
      state <= EMIT;
      pend  <= req;
      zReg  <= (req == '0);
    end else if (xfer) begin
      pend <= pend & ~(REQ_W'(1) << code);
      if (last) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_encoder8_serializer.sv
// Directed self-checking bench for encoder8_serializer; an LSB-first and an
// MSB-first instance share the same stimulus.
module tb_encoder8_serializer;
  import encoder8_serializer_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              inValid = 1'b0;
  logic [REQ_W-1:0]  req = '0;
  logic              outReady = 1'b0;

  logic              inReady, outValid, last, zero;
  logic [CODE_W-1:0] code;
  logic              mInReady, mOutValid, mLast, mZero;
  logic [CODE_W-1:0] mCode;

  int checkCount = 0;
  int errCount   = 0;

  logic [2:0] expL1 [3] = '{3'd2, 3'd5, 3'd7};
  logic [2:0] expM1 [3] = '{3'd7, 3'd5, 3'd2};
  logic [3:0] readyPat = 4'b1001;

  always #5 clk = ~clk;

  encoder8_serializer #(.LSB_FIRST(1'b1)) dutLsb (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady), .req(req),
    .outValid(outValid), .outReady(outReady), .code(code), .last(last), .zero(zero)
  );

  encoder8_serializer #(.LSB_FIRST(1'b0)) dutMsb (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(mInReady), .req(req),
    .outValid(mOutValid), .outReady(outReady), .code(mCode), .last(mLast), .zero(mZero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [REQ_W-1:0] r, input logic rdy);
    inValid  = v;
    req      = r;
    outReady = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst outValid", 32'(outValid), 0);
    checkOutput("rst code", 32'(code), 0);
    checkOutput("rst last", 32'(last), 0);
    checkOutput("rst zero", 32'(zero), 0);
    checkOutput("rst inReady", 32'(inReady), 1);
    rst_n = 1'b1;

    // 8'b1010_0100 in both priority directions
    tick();
    applyStimulus(1'b1, 8'hA4, 1'b1);
    @(negedge clk);
    checkOutput("t1 idle inReady", 32'(inReady), 1);
    checkOutput("t1 idle outValid", 32'(outValid), 0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t1 outValid", 32'(outValid), 1);
      checkOutput("t1 lsb code", 32'(code), 32'(expL1[i]));
      checkOutput("t1 lsb last", 32'(last), 32'(i == 2));
      checkOutput("t1 inReady", 32'(inReady), 32'(i == 2));
      checkOutput("t1 msb code", 32'(mCode), 32'(expM1[i]));
      checkOutput("t1 msb last", 32'(mLast), 32'(i == 2));
      checkOutput("t1 zero", 32'(zero), 0);
      tick();
    end
    @(negedge clk);
    checkOutput("t1 done outValid", 32'(outValid), 0);

    // All-zero vector, then 8'h01 accepted on the same edge as its beat
    tick();
    applyStimulus(1'b1, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h01, 1'b1);
    @(negedge clk);
    checkOutput("t3 zero valid", 32'(outValid), 1);
    checkOutput("t3 zero code", 32'(code), 0);
    checkOutput("t3 zero flag", 32'(zero), 1);
    checkOutput("t3 zero last", 32'(last), 1);
    checkOutput("t3 zero inReady", 32'(inReady), 1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("t3 one valid", 32'(outValid), 1);
    checkOutput("t3 one code", 32'(code), 0);
    checkOutput("t3 one zero", 32'(zero), 0);
    checkOutput("t3 one last", 32'(last), 1);
    tick();
    @(negedge clk);
    checkOutput("t3 done outValid", 32'(outValid), 0);

    // 8'hFF with a stalling consumer: outputs must hold through stalls
    tick();
    applyStimulus(1'b1, 8'hFF, 1'b1);
    tick();
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      applyStimulus(1'b0, 8'h00, readyPat[c % 4]);
      @(negedge clk);
      checkOutput("t4 outValid", 32'(outValid), 1);
      checkOutput("t4 lsb code", 32'(code), 32'(beats));
      checkOutput("t4 lsb last", 32'(last), 32'(beats == 7));
      checkOutput("t4 msb code", 32'(mCode), 32'(7 - beats));
      tick();
      if (readyPat[c % 4]) beats++;
    end
    checkOutput("t4 beat count", 32'(beats), 8);
    @(negedge clk);
    checkOutput("t4 done outValid", 32'(outValid), 0);

    // Back-to-back 8'h81 then 8'h10 with inValid held
    tick();
    applyStimulus(1'b1, 8'h81, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h10, 1'b1);
    @(negedge clk);
    checkOutput("t5 b0 code", 32'(code), 0);
    checkOutput("t5 b0 last", 32'(last), 0);
    checkOutput("t5 b0 inReady", 32'(inReady), 0);
    tick();
    @(negedge clk);
    checkOutput("t5 b1 code", 32'(code), 7);
    checkOutput("t5 b1 last", 32'(last), 1);
    checkOutput("t5 b1 inReady", 32'(inReady), 1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("t5 b2 valid", 32'(outValid), 1);
    checkOutput("t5 b2 code", 32'(code), 4);
    checkOutput("t5 b2 last", 32'(last), 1);
    tick();
    @(negedge clk);
    checkOutput("t5 done outValid", 32'(outValid), 0);

    // Asynchronous reset during beat 2 of 8'hFF
    tick();
    applyStimulus(1'b1, 8'hFF, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("t6 b1 code", 32'(code), 0);
    tick();
    @(negedge clk);
    checkOutput("t6 b2 code", 32'(code), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6 rst outValid", 32'(outValid), 0);
    checkOutput("t6 rst inReady", 32'(inReady), 1);
    checkOutput("t6 rst code", 32'(code), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 8'h08, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("t6 post valid", 32'(outValid), 1);
    checkOutput("t6 post code", 32'(code), 3);
    checkOutput("t6 post last", 32'(last), 1);
    checkOutput("t6 post zero", 32'(zero), 0);
    tick();
    @(negedge clk);
    checkOutput("t6 done outValid", 32'(outValid), 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
